// File: rtl/addon_pkg.sv
// Shared widths, FSM states and output saturation for the pythag_addon engine.
// Build option: define ADDON_ROUND_EN for round-to-nearest results.
package addon_pkg;

    localparam int DATA_W  = 8;
    localparam int SUM_W   = 17;
    localparam int ROOT_W  = 9;
    localparam int ITER    = 9;
    localparam int SAT_MAX = 255;
    localparam int REM_W   = ROOT_W + 1;
    localparam int CNT_W   = 4;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    function automatic logic [DATA_W-1:0] sat(
        input logic [ROOT_W:0] v
    );
        if (v > (ROOT_W+1)'(SAT_MAX)) begin
            return DATA_W'(SAT_MAX);
        end
        return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/pythag_addon_if.sv
// TinyTapeout-style pin bundle between the user slot and its driver.
// Build option ADDON_ROUND_EN does not affect this interface.
interface pythag_addon_if;
    import addon_pkg::*;

    logic              ena;
    logic [DATA_W-1:0] ui_in;
    logic [DATA_W-1:0] uio_in;
    logic [DATA_W-1:0] uo_out;
    logic [DATA_W-1:0] uio_out;
    logic [DATA_W-1:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface

// File: rtl/pythag_addon_isqrt_seq.sv
// Bit-serial digit-by-digit square root, 17-bit radicand to 9-bit root.
// root/rem/done show this cycle's step result so the caller can register it.
module isqrt_seq
    import addon_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SUM_W-1:0]  radicand,
    output logic [ROOT_W-1:0] root,
    output logic [REM_W-1:0]  rem,
    output logic              done
);

    logic [SUM_W:0]      s_q;
    logic [ROOT_W-1:0]   root_q;
    logic [REM_W-1:0]    rem_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                act_q;

    logic [REM_W+1:0]    acc;
    logic [REM_W+1:0]    trial;
    logic [REM_W-1:0]    diff;
    logic                ge;

    // Bring down the next bit pair and test root*4+1 against it.
    assign acc   = {rem_q, s_q[SUM_W:SUM_W-1]};
    assign trial = {1'b0, root_q, 2'b01};
    assign ge    = acc >= trial;
    assign diff  = acc[REM_W-1:0] - trial[REM_W-1:0];

    assign root = {root_q[ROOT_W-2:0], ge};
    assign rem  = ge ? diff : acc[REM_W-1:0];
    assign done = act_q && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
        end else if (load) begin
            s_q    <= {1'b0, radicand};
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= CNT_W'(ITER - 1);
            act_q  <= 1'b1;
        end else if (act_q) begin
            s_q    <= s_q << 2;
            root_q <= root;
            rem_q  <= rem;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                act_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pythag_addon.sv
// Sequential floor(sqrt(X^2+Y^2)) engine for the TinyTapeout user slot.
// Define ADDON_ROUND_EN to round the result to nearest instead of floor.
module pythag_addon
    import addon_pkg::*;
(
    input logic           clk,
    input logic           rst,
    pythag_addon_if.slave bus
);

    state_t              state_q;
    state_t              state_d;
    logic                rst_q;
    logic                load;
    logic                out_we;
    logic [DATA_W-1:0]   uo_q;
    logic [DATA_W-1:0]   res;

    logic [SUM_W-1:0]    x_ext;
    logic [SUM_W-1:0]    y_ext;
    logic [SUM_W-1:0]    sum;

    logic [ROOT_W-1:0]   root;
    logic [REM_W-1:0]    rem;
    logic                done;

    assign x_ext = SUM_W'(bus.ui_in);
    assign y_ext = SUM_W'(bus.uio_in);
    assign sum   = x_ext * x_ext + y_ext * y_ext;

    isqrt_seq u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .radicand (sum),
        .root     (root),
        .rem      (rem),
        .done     (done)
    );

`ifdef ADDON_ROUND_EN
    logic [ROOT_W:0] root_r;

    // Remainder above root means sqrt(S) >= root + 0.5.
    assign root_r = (rem > REM_W'(root))
                  ? {1'b0, root} + (ROOT_W+1)'(1)
                  : {1'b0, root};
    assign res = sat(root_r);
`else
    logic rem_unused;

    assign rem_unused = ^rem;
    assign res = sat({1'b0, root});
`endif

    // Holds off a start on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        out_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ena && !rst_q) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (done) begin
                    out_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uo_q <= '0;
        end else if (out_we) begin
            uo_q <= res;
        end
    end

    assign bus.uo_out  = uo_q;
    assign bus.uio_out = '0;
    assign bus.uio_oe  = '0;

endmodule

// File: tb/tb_pythag_addon.sv
// Directed table-driven bench for pythag_addon, floor or rounded build.
// Expected results are hand-computed per vector for both builds.
module tb_pythag_addon;
    import addon_pkg::*;

    logic clk;
    logic rst;
    int   passes;
    int   total;
    int   prev;

    pythag_addon_if bus();

    pythag_addon dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int flr;
        int rnd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got == want) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int pick(input vec_t v);
`ifdef ADDON_ROUND_EN
        return v.rnd;
`else
        return v.flr;
`endif
    endfunction

    // Call at a negedge; returns at the negedge after edge k+9.
    task automatic run_vec(input int x, input int y, input int want);
        bus.ui_in  = 8'(x);
        bus.uio_in = 8'(y);
        bus.ena    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ena = 1'b0;
        repeat (8) @(negedge clk);
        chk($sformatf("hold %0d,%0d", x, y), int'(bus.uo_out), prev);
        @(negedge clk);
        chk($sformatf("res %0d,%0d", x, y), int'(bus.uo_out), want);
        prev = want;
    endtask

    initial begin
        passes = 0;
        total  = 0;
        prev   = 0;
        vecs[0] = '{3, 4, 5, 5};
        vecs[1] = '{5, 12, 13, 13};
        vecs[2] = '{0, 0, 0, 0};
        vecs[3] = '{7, 7, 9, 10};
        vecs[4] = '{1, 1, 1, 1};
        vecs[5] = '{255, 255, 255, 255};
        vecs[6] = '{255, 0, 255, 255};
        vecs[7] = '{100, 200, 223, 224};
        vecs[8] = '{10, 10, 14, 14};

        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.ui_in  = '0;
        bus.uio_in = '0;
        repeat (2) @(negedge clk);
        chk("rst uo_out", int'(bus.uo_out), 0);
        chk("rst uio_out", int'(bus.uio_out), 0);
        chk("rst uio_oe", int'(bus.uio_oe), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back: each start lands on edge k+10 of the previous.
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i].x, vecs[i].y, pick(vecs[i]));
        end

        // ena and operand changes during CALC are ignored.
        bus.ui_in  = 8'd3;
        bus.uio_in = 8'd4;
        bus.ena    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ena = 1'b0;
        repeat (3) @(negedge clk);
        bus.ena    = 1'b1;
        bus.ui_in  = 8'd5;
        bus.uio_in = 8'd12;
        @(negedge clk);
        bus.ena   = 1'b0;
        bus.ui_in = 8'd200;
        repeat (4) @(negedge clk);
        chk("ign hold", int'(bus.uo_out), prev);
        @(negedge clk);
        chk("ign res", int'(bus.uo_out), 5);
        repeat (12) @(negedge clk);
        chk("ign noqueue", int'(bus.uo_out), 5);

        // Reset mid-CALC clears uo_out at once; start at release ignored.
        bus.ui_in  = 8'd5;
        bus.uio_in = 8'd12;
        bus.ena    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ena = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async rst", int'(bus.uo_out), 0);
        @(negedge clk);
        bus.ui_in  = 8'd3;
        bus.uio_in = 8'd4;
        bus.ena    = 1'b1;
        rst        = 1'b0;
        @(negedge clk);
        bus.ena = 1'b0;
        repeat (12) @(negedge clk);
        chk("post rst idle", int'(bus.uo_out), 0);
        prev = 0;
        run_vec(8, 6, 10);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
